// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response path.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to each transmitted frame.
package uart_cmd_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 8;

  localparam logic [7:0] CMD_LED_ON   = 8'hA1;
  localparam logic [7:0] CMD_LED_OFF  = 8'hA2;
  localparam logic [7:0] CMD_READ_LED = 8'hB1;
  localparam logic [7:0] CMD_RESET    = 8'hC1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Response byte FIFO: registered read/write pointers with an extra wrap bit
// so that full and empty can be told apart when the indices match.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // pointer update; a simultaneous push and pop both advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_resp_tx.sv
// UART response transmitter: FIFO-buffered bytes sent 8N1, LSB first, back to back.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_resp_tx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       resp_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [2:0]    next_idx;
  logic [7:0]    shift;
  logic          baud_end;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          push;
  logic          pop;

  assign resp_ready = !fifo_full;
  assign push       = resp_valid && !fifo_full;
  assign baud_end   = (baud == BAUD_LAST);
  assign next_idx   = bit_idx + 3'd1;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (resp_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pop when idle, or at the end of a stop bit so the next start follows with no gap
  always_comb begin
    pop = 1'b0;
    if (fifo_empty) begin
      pop = 1'b0;
    end else if (state == TX_IDLE) begin
      pop = 1'b1;
    end else if ((state == TX_STOP) && baud_end) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // frame FSM with registered tx and busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          baud    <= '0;
          bit_idx <= 3'd0;
          if (pop) begin
            shift <= fifo_rdata;
            state <= TX_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= push;
          end
        end
        TX_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            tx      <= shift[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= next_idx;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= TX_PARITY;
              tx    <= even_parity(shift);
`else
              state <= TX_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift[next_idx];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            state <= TX_STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        TX_STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (pop) begin
              shift <= fifo_rdata;
              state <= TX_START;
              tx    <= 1'b0;
            end else begin
              state <= TX_IDLE;
              tx    <= 1'b1;
              busy  <= push;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state   <= TX_IDLE;
          baud    <= '0;
          bit_idx <= 3'd0;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_resp_tx.md
UART_RESP_TX -- requirements
Module: uart_resp_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clocks per UART bit (160 ns at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning response bytes buffered, power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port resp_valid, input, 1 bit: a response byte is offered.
REQ-006 SHALL have port resp_data, input, 8 bits: response byte (status, LED readback, echo).
REQ-007 SHALL have port resp_ready, output, 1 bit: a byte is accepted at an edge when resp_valid and resp_ready are both 1.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high, LSB first.
REQ-009 SHALL have port busy, output, 1 bit: 1 while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL drive resp_ready = NOT fifo_full, combinationally from registered FIFO state.
REQ-011 SHALL write resp_data into the FIFO on every accepted handshake; an offer while full SHALL be ignored and the byte SHALL NOT be lost, because the source holds it.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-013 In IDLE with the FIFO non-empty, SHALL pop one byte into the shift register and enter START at the same edge.
REQ-014 The first low tx cycle SHALL begin at the clock edge after the accepting edge when the FIFO was empty and the FSM was in IDLE: latency 1 clock.
REQ-015 Each bit SHALL be held for exactly CLKS_PER_BIT clocks, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-016 START SHALL drive tx=0; DATA SHALL drive bits 0..7 in order using a 3-bit index that wraps; STOP SHALL drive tx=1.
REQ-017 At the end of STOP, SHALL go directly to START (popping the next byte) if the FIFO is non-empty, with no idle gap; otherwise SHALL go to IDLE.
REQ-018 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-019 tx SHALL be a register output with no combinational glitches.
REQ-020 busy SHALL deassert in the cycle after the last stop bit completes with the FIFO empty.

Reset
REQ-021 rst low SHALL immediately set tx=1, busy=0, FIFO empty, state IDLE, and all counters 0; resp_ready SHALL become 1.
REQ-022 rst asserted mid-frame SHALL abort the frame, with tx returning high asynchronously; no partial byte SHALL be resumed after release.
REQ-023 The first handshake SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, SHALL insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP; frame = 11 bits.
REQ-025 Without UART_TX_PARITY_EN, PARITY state and logic SHALL be absent; frame = 10 bits.

Structure
REQ-026 Package uart_cmd_pkg SHALL hold the tx state typedef, command codes (A1 LED ON, A2 LED OFF, B1 READ LED, C1 RESET) and the default CLKS_PER_BIT.
REQ-027 The FIFO SHALL be a sub-module uart_tx_fifo with push/pop/full/empty, registered pointers and an extra wrap bit for full/empty detection.
REQ-028 uart_resp_tx SHALL contain the FSM, baud counter, bit index and shift register only.

Verification
REQ-029 Single byte: push 0xA1 into an idle block -> tx low 8 clocks, then bits 1,0,0,0,0,1,0,1 for 8 clocks each, then high 8 clocks; 80 clocks total (88 with parity, parity bit = 1).
REQ-030 Back-to-back: push 0xA1, 0xA2, 0xB1 on consecutive cycles -> 240 contiguous frame clocks with no idle cycles, bytes in order; busy falls on clock 241.
REQ-031 Full: hold resp_valid with FIFO_DEPTH+1 bytes while the first frame is transmitting -> resp_ready low once the FIFO is full; the held byte is sent after the FIFO frees a slot; no byte is dropped or duplicated.
REQ-032 Reset mid-frame: assert rst during DATA bit 3 of 0xC1 -> tx=1 without waiting for a clock edge, resp_ready=1, no further frame; then push 0xA2 -> a clean frame starts 1 clock later.
REQ-033 Loopback: connect tx to the uart_command_top rx input and send A1 then A2 -> led goes to 1 and then to 0.
REQ-034 Parity build: 0xA2 (3 ones) -> parity bit 1; 0xC1 (3 ones) -> 1; 0x00 -> 0.
